present_key_sched_stream: RTL
=============================

Name: present_key_sched_stream

Overview:
- Parametrised, clocked PRESENT key schedule supporting 80-bit and 128-bit master keys.
- Loads a master key, then emits round keys K1..K(NUM_ROUNDS+1) one per accepted handshake on a valid/ready stream.
- Owns its own round counter, so the consuming datapath does not drive it.
- Sits between key input registers and the round datapath of the PRESENT encryption core.

Parameters:
- KEY_WIDTH, 80, master key width; only 80 or 128 legal, any other value is an elaboration error.
- NUM_ROUNDS, 31, number of key-update steps; emits NUM_ROUNDS+1 round keys; legal range 1..31.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- key_in  input  KEY_WIDTH  master key, sampled when key_load=1.
- key_load  input  1  load pulse; starts (or restarts) a schedule.
- rk_valid  output  1  round_key/round_idx hold a valid round key.
- rk_ready  input  1  consumer accepts the current round key.
- round_key  output  64  current round key = state[KEY_WIDTH-1:KEY_WIDTH-64].
- round_idx  output  6  index of current round key, 1..NUM_ROUNDS+1.
- busy  output  1  a schedule is in progress.
- done  output  1  one-cycle pulse after the last round key is accepted.

Behaviour:
- Reset (async, reset_n=0): state=0, round_key=0, round_idx=0, rk_valid=0, busy=0, done=0, FSM=IDLE.
- FSM states:
  - IDLE: rk_valid=0, busy=0.
  - EMIT: rk_valid=1, busy=1.
- key_load=1 in any state: at the next edge state<=key_in, round_idx<=1, FSM<=EMIT. K1 = key_in[KEY_WIDTH-1:KEY_WIDTH-64] is valid one cycle after the load.
- Handshake: a transfer occurs when rk_valid && rk_ready.
  - rk_valid stays high and round_key/round_idx stay stable until the transfer.
- Transfer with round_idx=i <= NUM_ROUNDS: next edge applies update(i), round_idx<=i+1, rk_valid stays 1.
  - Full throughput: one key per cycle with rk_ready held high.
- Transfer with round_idx=NUM_ROUNDS+1: FSM<=IDLE, rk_valid<=0, done<=1 for exactly one cycle. round_key and round_idx hold their last values.
- Update, KEY_WIDTH=80:
  - rotate state left by 61.
  - [79:76] <= S([79:76]).
  - [19:15] ^= i[4:0].
- Update, KEY_WIDTH=128:
  - rotate state left by 61.
  - [127:124] <= S([127:124]) and [123:120] <= S([123:120]).
  - [66:62] ^= i[4:0].
- S-box (PRESENT): 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
- Simultaneous key_load and transfer: load wins. The schedule restarts at K1 and no done pulse is issued, even on the final key.
- key_load in EMIT (mid-schedule): abort, restart at K1 next cycle, no done.
- rk_ready while IDLE is ignored.
- key_in is sampled only on key_load; later changes have no effect.
- Reset asserted mid-schedule returns all outputs to reset values immediately (asynchronous).
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package present_pkg holds:
  - the S-box constant table.
  - PRESENT_ROT = 61.
  - the counter XOR field positions for 80/128 (lsb 15 and 62).
  - ROUND_KEY_W = 64.
- One sub-module, present_sbox4: combinational 4-bit S-box.
  - Instantiated once for 80-bit, twice for 128-bit (generate on KEY_WIDTH).
  - Reused by the round datapath.

Test Plan:
- KEY_WIDTH=80, key_in=0, load, rk_ready=1:
  - K1=0x0000000000000000, K2=0xC000000000000000, K3=0x5000180000000001.
  - round_idx 1,2,3; 32 keys on consecutive cycles.
  - done pulses one cycle after idx 32.
- KEY_WIDTH=80, key_in=0 and all-F keys, round keys fed to a reference PRESENT round model:
  - encrypting plaintext 0 with key 0 gives ciphertext 0x5579C1387B228445.
  - plaintext 0 with key all-F gives 0xE72C46C0F5945049.
- KEY_WIDTH=128, key 0 and all-F, all 32 round keys compared against the golden software schedule:
  - exact match required.
  - plaintext 0 with key 0 gives ciphertext 0x96DB702A2E6900AF.
- Backpressure: rk_ready toggled randomly (including long low stretches):
  - round_key and round_idx stable while rk_valid=1 and rk_ready=0.
  - no key skipped or duplicated.
  - sequence identical to the rk_ready=1 run.
- key_load at idx 17, and key_load coincident with the final transfer:
  - next cycle shows idx=1 with K1 of the new key.
  - no done pulse in either case.
- reset_n pulsed low mid-schedule, asynchronously between edges:
  - rk_valid, busy, done, round_idx and round_key go to 0 without waiting for a clock edge.
  - the next load behaves normally.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT constants: S-box table, key-rotation amount and
// round-counter injection positions for both master key widths.
package present_pkg;

    localparam int ROUND_KEY_W  = 64;
    localparam int PRESENT_ROT  = 61;
    localparam int CTR_W        = 5;
    localparam int XOR_LSB_80   = 15;
    localparam int XOR_LSB_128  = 62;

    // Nibble n of this word is S(n); entry 0 sits in the least significant nibble.
    localparam logic [63:0] SBOX_TABLE = 64'h2174_8FE3_DA09_B65C;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } sched_state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    // Bit position where the 5-bit round counter is XORed into the key state.
    function automatic int ctr_xor_lsb(input int key_width);
        return (key_width == 128) ? XOR_LSB_128 : XOR_LSB_80;
    endfunction

endpackage

// File: rtl/present_sbox4.sv
// Combinational 4-bit PRESENT S-box, shared by key schedule and round datapath.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // pure table lookup
    always_comb begin
        nib_out = sbox4(nib_in);
    end

endmodule

// File: rtl/present_key_sched_stream.sv
// PRESENT key schedule that streams round keys K1..K(NUM_ROUNDS+1) over a
// valid/ready interface, tracking its own round counter.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | no schedule running; rk_valid=0, busy=0
//   ST_EMIT | round_key/round_idx hold a key awaiting rk_ready
module present_key_sched_stream
    import present_pkg::*;
#(
    parameter int KEY_WIDTH  = 80,
    parameter int NUM_ROUNDS = 31
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic                   key_load,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic [ROUND_KEY_W-1:0] round_key,
    output logic [5:0]             round_idx,
    output logic                   busy,
    output logic                   done
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS + 1);
    localparam int         XOR_LSB  = ctr_xor_lsb(KEY_WIDTH);

    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_num_rounds
        $error("present_key_sched_stream: NUM_ROUNDS must be within 1..31");
    end

    sched_state_e          fsm_q, fsm_d;
    logic [KEY_WIDTH-1:0]  state_q, state_d;
    logic [5:0]            idx_q, idx_d;
    logic                  done_q, done_d;

    logic [KEY_WIDTH-1:0]  rot;
    logic [KEY_WIDTH-1:0]  subst;
    logic [KEY_WIDTH-1:0]  ctr_mask;
    logic [KEY_WIDTH-1:0]  upd;
    logic                  xfer;

    // rotate left by 61, then substitute the top nibble(s)
    always_comb begin
        rot = {state_q[KEY_WIDTH-PRESENT_ROT-1:0], state_q[KEY_WIDTH-1:KEY_WIDTH-PRESENT_ROT]};
    end

    if (KEY_WIDTH == 80) begin : g_k80
        logic [3:0] sb_hi;
        present_sbox4 u_sbox_hi (
            .nib_in  (rot[KEY_WIDTH-1 -: 4]),
            .nib_out (sb_hi)
        );
        // only the top nibble passes through the S-box for 80-bit keys
        always_comb begin
            subst = {sb_hi, rot[KEY_WIDTH-5:0]};
        end
    end else if (KEY_WIDTH == 128) begin : g_k128
        logic [3:0] sb_hi;
        logic [3:0] sb_lo;
        present_sbox4 u_sbox_hi (
            .nib_in  (rot[KEY_WIDTH-1 -: 4]),
            .nib_out (sb_hi)
        );
        present_sbox4 u_sbox_lo (
            .nib_in  (rot[KEY_WIDTH-5 -: 4]),
            .nib_out (sb_lo)
        );
        // the top two nibbles pass through the S-box for 128-bit keys
        always_comb begin
            subst = {sb_hi, sb_lo, rot[KEY_WIDTH-9:0]};
        end
    end else begin : g_bad_key_width
        $error("present_key_sched_stream: KEY_WIDTH must be 80 or 128");
    end

    // inject the index of the key just consumed; this produces the next key
    always_comb begin
        ctr_mask = KEY_WIDTH'(idx_q[CTR_W-1:0]) << XOR_LSB;
        upd      = subst ^ ctr_mask;
    end

    // next-state: load beats transfer, last transfer ends with a done pulse
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        xfer    = (fsm_q == ST_EMIT) && rk_ready;

        if (key_load) begin
            fsm_d   = ST_EMIT;
            state_d = key_in;
            idx_d   = 6'd1;
        end else if (xfer) begin
            if (idx_q == LAST_IDX) begin
                // round_key and round_idx keep showing the final key
                fsm_d  = ST_IDLE;
                done_d = 1'b1;
            end else begin
                state_d = upd;
                idx_d   = idx_q + 6'd1;
            end
        end
    end

    // register all schedule state; async reset clears every output at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // every output is a flop or a direct slice of one
    always_comb begin
        rk_valid  = (fsm_q == ST_EMIT);
        busy      = (fsm_q == ST_EMIT);
        round_key = state_q[KEY_WIDTH-1 -: ROUND_KEY_W];
        round_idx = idx_q;
        done      = done_q;
    end

endmodule
